// File: rtl/led_sweep_gen_if.sv
// Control/status bundle between the LED sweep generator and its user.
//   i_run       level, 1 = sweep active
//   i_mode_btn  one-cycle pulse, advances the sweep mode
//   i_speed     step-period multiplier select (x1, x2, x4, x8)
//   o_led_data  LED index, 0 = all off, 1..9 = lit position
//   o_mode      current mode: 00 BOUNCE, 01 UP, 10 DOWN
//   o_step      one-cycle pulse when o_led_data advances
interface led_sweep_gen_if;
    logic       i_run;
    logic       i_mode_btn;
    logic [1:0] i_speed;
    logic [3:0] o_led_data;
    logic [1:0] o_mode;
    logic       o_step;

    modport slave (
        input  i_run,
        input  i_mode_btn,
        input  i_speed,
        output o_led_data,
        output o_mode,
        output o_step
    );

    modport master (
        output i_run,
        output i_mode_btn,
        output i_speed,
        input  o_led_data,
        input  o_mode,
        input  o_step
    );
endinterface

// File: rtl/led_sweep_gen.sv
// LED sweep generator: walks a lit position 1..9 in BOUNCE, UP or DOWN mode,
// advancing once every STEP_CYCLES * (1, 2, 4, 8) clocks while running.
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    led_sweep_gen_if slave: run/mode/speed in, led/mode/step out
module led_sweep_gen #(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned STEP_MS = 100
) (
    input  logic                   clk,
    input  logic                   rst_n,
    led_sweep_gen_if.slave         bus
);

    localparam int unsigned STEP_CYCLES = CLK_HZ / 1000 * STEP_MS;
    // Wide enough for the largest terminal count, STEP_CYCLES*8-1.
    localparam int unsigned CNT_W = $clog2(STEP_CYCLES * 8);

    localparam logic [1:0] ModeBounce = 2'b00;
    localparam logic [1:0] ModeUp     = 2'b01;
    localparam logic [1:0] ModeDown   = 2'b10;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic             dir_up_q, dir_up_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       led_q, led_d;
    logic             step_q, step_d;

    logic [1:0]       mode_eff;
    logic [1:0]       mode_next;
    logic [3:0]       start_pos;
    logic [CNT_W-1:0] term;
    logic [3:0]       adv_led;
    logic             adv_dir_up;

    // Terminal count follows the live i_speed so a slowdown-to-faster change
    // mid-count steps at once via the >= compare below.
    assign term = CNT_W'((STEP_CYCLES << bus.i_speed) - 1);

    always_comb begin
        // Unused encoding 11 behaves as BOUNCE.
        mode_eff  = (mode_q == 2'b11) ? ModeBounce : mode_q;
        mode_next = (mode_eff == ModeDown) ? ModeBounce : mode_eff + 2'd1;
    end

    always_comb begin
        adv_led    = led_q;
        adv_dir_up = dir_up_q;
        unique case (mode_eff)
            ModeUp:   adv_led = (led_q >= 4'd9) ? 4'd1 : led_q + 4'd1;
            ModeDown: adv_led = (led_q <= 4'd1) ? 4'd9 : led_q - 4'd1;
            default: begin
                // Turn around at the ends with no dwell.
                if (led_q >= 4'd9) begin
                    adv_led    = 4'd8;
                    adv_dir_up = 1'b0;
                end else if (led_q <= 4'd1) begin
                    adv_led    = 4'd2;
                    adv_dir_up = 1'b1;
                end else begin
                    adv_led = dir_up_q ? led_q + 4'd1 : led_q - 4'd1;
                end
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = bus.i_mode_btn ? mode_next : mode_q;
        dir_up_d  = dir_up_q;
        cnt_d     = cnt_q;
        led_d     = led_q;
        step_d    = 1'b0;
        start_pos = (mode_d == ModeDown) ? 4'd9 : 4'd1;

        unique case (state_q)
            StIdle: begin
                led_d = 4'd0;
                cnt_d = '0;
                if (bus.i_run) begin
                    state_d  = StRun;
                    led_d    = start_pos;
                    dir_up_d = 1'b1;
                end
            end
            default: begin
                if (!bus.i_run) begin
                    state_d = StIdle;
                    led_d   = 4'd0;
                    cnt_d   = '0;
                end else if (bus.i_mode_btn) begin
                    // Mode change restarts the sweep and overrides any step.
                    led_d    = start_pos;
                    cnt_d    = '0;
                    dir_up_d = 1'b1;
                end else if (cnt_q >= term) begin
                    cnt_d    = '0;
                    led_d    = adv_led;
                    dir_up_d = adv_dir_up;
                    step_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            mode_q   <= ModeBounce;
            dir_up_q <= 1'b1;
            cnt_q    <= '0;
            led_q    <= 4'd0;
            step_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            dir_up_q <= dir_up_d;
            cnt_q    <= cnt_d;
            led_q    <= led_d;
            step_q   <= step_d;
        end
    end

    assign bus.o_led_data = led_q;
    assign bus.o_mode     = mode_q;
    assign bus.o_step     = step_q;

endmodule

// File: tb/tb_led_sweep_gen.sv
module tb_led_sweep_gen;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;
    int   n_fail;
    logic [3:0] exp_led;

    led_sweep_gen_if bus ();

    led_sweep_gen #(
        .CLK_HZ  (1000),
        .STEP_MS (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expect the current LED to hold for period-1 cycles, then step to nxt.
    task automatic do_step(input string tag, input int period, input logic [3:0] nxt);
        for (int i = 0; i < period - 1; i++) begin
            tick();
            chk({tag, "_hold"}, {27'd0, bus.o_step, bus.o_led_data}, {27'd0, 1'b0, exp_led});
        end
        tick();
        chk({tag, "_step"}, {27'd0, bus.o_step, bus.o_led_data}, {27'd0, 1'b1, nxt});
        exp_led = nxt;
    endtask

    initial begin
        logic [3:0] bounce_seq [28];
        logic [3:0] up_seq [9];
        logic [3:0] down_seq [9];
        bounce_seq = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd8, 4'd7,
                       4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
                       4'd6, 4'd7, 4'd8, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5};
        up_seq     = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd1, 4'd2};
        down_seq   = '{4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd9};
        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;

        rst_n          = 1'b0;
        bus.i_run      = 1'b0;
        bus.i_mode_btn = 1'b0;
        bus.i_speed    = 2'b00;
        tick();
        tick();
        chk("rst_led", bus.o_led_data, 0);
        chk("rst_mode", bus.o_mode, 0);
        chk("rst_step", bus.o_step, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_led", bus.o_led_data, 0);

        // BOUNCE at x1: start at 1, sweep up and down, then reach 5 going down.
        bus.i_run = 1'b1;
        tick();
        chk("bnc_start_led", bus.o_led_data, 1);
        chk("bnc_start_step", bus.o_step, 0);
        exp_led = 4'd1;
        for (int i = 0; i < 28; i++) do_step("bnc", 4, bounce_seq[i]);

        // Mode pulse at 5 (direction down) -> UP, restart at 1.
        bus.i_mode_btn = 1'b1;
        tick();
        bus.i_mode_btn = 1'b0;
        chk("mbtn_mode", bus.o_mode, 1);
        chk("mbtn_led", bus.o_led_data, 1);
        chk("mbtn_step", bus.o_step, 0);
        exp_led = 4'd1;
        do_step("up_x1", 4, 4'd2);

        // UP at x2: every 8 cycles, wrapping 9 -> 1.
        bus.i_speed = 2'b01;
        for (int i = 0; i < 9; i++) do_step("up_x2", 8, up_seq[i]);

        // DOWN at x2: restart at 9, wrapping 1 -> 9.
        bus.i_mode_btn = 1'b1;
        tick();
        bus.i_mode_btn = 1'b0;
        chk("down_mode", bus.o_mode, 2);
        chk("down_start", bus.o_led_data, 9);
        exp_led = 4'd9;
        for (int i = 0; i < 9; i++) do_step("down_x2", 8, down_seq[i]);

        // x8 for 20 counts, then x1: immediate step, then every 4.
        bus.i_speed = 2'b11;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("x8_hold", {27'd0, bus.o_step, bus.o_led_data}, {27'd0, 1'b0, 4'd9});
        end
        bus.i_speed = 2'b00;
        tick();
        chk("spd_drop_step", bus.o_step, 1);
        chk("spd_drop_led", bus.o_led_data, 8);
        exp_led = 4'd8;
        do_step("spd_after", 4, 4'd7);

        // Run falls together with a mode pulse at 7.
        bus.i_run      = 1'b0;
        bus.i_mode_btn = 1'b1;
        tick();
        bus.i_mode_btn = 1'b0;
        chk("stop_led", bus.o_led_data, 0);
        chk("stop_mode", bus.o_mode, 0);
        chk("stop_step", bus.o_step, 0);
        tick();
        chk("idle_hold_led", bus.o_led_data, 0);
        // Mode pulse in IDLE only moves the mode.
        bus.i_mode_btn = 1'b1;
        tick();
        bus.i_mode_btn = 1'b0;
        chk("idle_btn_mode", bus.o_mode, 1);
        chk("idle_btn_led", bus.o_led_data, 0);
        bus.i_run = 1'b1;
        tick();
        chk("restart_led", bus.o_led_data, 1);
        chk("restart_mode", bus.o_mode, 1);

        // DOWN down to 4, then reset mid-sweep with run and a mode pulse held.
        bus.i_mode_btn = 1'b1;
        tick();
        bus.i_mode_btn = 1'b0;
        chk("d2_start", bus.o_led_data, 9);
        exp_led = 4'd9;
        for (int i = 0; i < 5; i++) do_step("d2", 4, down_seq[i]);
        rst_n          = 1'b0;
        bus.i_mode_btn = 1'b1;
        tick();
        bus.i_mode_btn = 1'b0;
        chk("midrst_led", bus.o_led_data, 0);
        chk("midrst_mode", bus.o_mode, 0);
        chk("midrst_step", bus.o_step, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_led", bus.o_led_data, 1);
        chk("post_rst_mode", bus.o_mode, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/led_sweep_gen.md
LED_SWEEP_GEN -- requirements
Module: led_sweep_gen

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 Parameter STEP_MS, default 100, base step period in ms; STEP_CYCLES = CLK_HZ/1000*STEP_MS, with STEP_CYCLES >= 2.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 i_run  input  1  level; 1 = sweep active, 0 = idle.
REQ-006 i_mode_btn  input  1  single-cycle pulse (already debounced); advances sweep mode.
REQ-007 i_speed  input  2  step-period multiplier: 00 = x1, 01 = x2, 10 = x4, 11 = x8 STEP_CYCLES.
REQ-008 o_led_data  output  4  LED index for the downstream LED controller; 0 = all off, 1..9 = lit position.
REQ-009 o_mode  output  2  current mode: 00 BOUNCE, 01 UP, 10 DOWN.
REQ-010 o_step  output  1  one-cycle pulse, asserted in the same cycle o_led_data takes an advanced value.

Function
REQ-011 The block SHALL implement a two-state FSM, IDLE and RUN, plus a separate mode register, a direction bit (used in BOUNCE only) and a step counter.
REQ-012 Start position SHALL be 1 for BOUNCE and UP and 9 for DOWN; BOUNCE SHALL start with direction up.
REQ-013 IDLE with i_run=1 SHALL move to RUN on the next edge, load o_led_data with the start position and clear the counter, with o_step=0.
REQ-014 RUN with i_run=0 SHALL move to IDLE on the next edge, with o_led_data=0, counter=0 and o_step=0.
REQ-015 In IDLE, o_led_data SHALL hold 0 and the counter SHALL hold 0.
REQ-016 In RUN, the counter SHALL increment each cycle; terminal count T = STEP_CYCLES*mult-1, computed from the current i_speed.
REQ-017 When counter >= T (">=" so that a mid-count speed decrease steps immediately), the block SHALL clear the counter, advance o_led_data and pulse o_step on the next edge.
REQ-018 The step period SHALL therefore be exactly STEP_CYCLES*mult cycles while i_speed is stable.
REQ-019 UP advance SHALL be +1, with 9 wrapping to 1.
REQ-020 DOWN advance SHALL be -1, with 1 wrapping to 9.
REQ-021 BOUNCE SHALL step by ±1 per the direction bit. At 9 it SHALL set direction down and go to 8. At 1 it SHALL set direction up and go to 2. There is no dwell at the endpoints.
REQ-022 i_mode_btn SHALL advance the mode 00->01->10->00; a mode register value of 11 SHALL be treated as 00 and the next pulse SHALL load 01.
REQ-023 A mode pulse in RUN SHALL, on the next edge, load the new mode's start position, clear the counter, reset the direction to up, and keep o_step=0; it SHALL take priority over a coincident step.
REQ-024 A mode pulse in IDLE SHALL change only o_mode.
REQ-025 If a mode pulse coincides with i_run falling, the mode SHALL advance and the FSM SHALL go to IDLE with o_led_data=0.
REQ-026 o_led_data SHALL never leave the range 0..9, and SHALL be nonzero exactly when the FSM is in RUN.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 With rst_n=0 sampled at a rising edge, the block SHALL enter IDLE with o_led_data=0, o_mode=00, o_step=0, counter=0 and direction up, regardless of the current state, including mid-sweep.
REQ-029 While rst_n=0, all inputs SHALL be ignored; normal operation SHALL resume on the first edge with rst_n=1.

Verification (CLK_HZ=1000, STEP_MS=4, so STEP_CYCLES=4)
REQ-030 Reset, then i_run=1 with BOUNCE and i_speed=00 -> o_led_data=1 one cycle after, then 2,3,...,9,8,...,1,2 every 4 cycles, with o_step high exactly one cycle per change.
REQ-031 UP mode, i_speed=01 -> steps every 8 cycles, sequence ...8,9,1,2; DOWN mode -> 9,8,...,1,9.
REQ-032 i_speed changed 11->00 at counter=20 -> step on the next edge, then every 4 cycles.
REQ-033 Mode pulse in BOUNCE at o_led_data=5 with direction down -> next cycle o_mode=01, o_led_data=1, o_step=0, next step after 4 cycles to 2.
REQ-034 i_run falling together with a mode pulse at o_led_data=7 -> next cycle o_led_data=0, IDLE, o_mode advanced; i_run=1 again -> start position of the new mode.
REQ-035 rst_n=0 for 1 cycle mid-sweep (DOWN, o_led_data=4, i_run held 1) -> o_led_data=0, o_mode=00; then with rst_n=1 and i_run=1 -> o_led_data=1 on the following edge.
